// File: rtl/uart_rx_ctl_module.sv
// UART receive controller: start, 8 data bits LSB first, optional parity, stop.
// Define UART_RX_MAJORITY_EN for a 2-of-3 majority vote at every sample point.
module uart_rx_ctl_module #(
    parameter int CLK_DIV = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_pin,
    input  logic [1:0] FrameCheck,
    output logic [7:0] RBUF,
    output logic       Doneflg,
    output logic       Parerr,
    output logic       Frmerr,
    output logic       Busy
);
    localparam int HALF_DIV = CLK_DIV / 2;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] SAMPLE_LAG = 16'd1;
`else
    localparam logic [15:0] SAMPLE_LAG = 16'd0;
`endif
    localparam logic [15:0] START_AT = 16'(HALF_DIV - 1) + SAMPLE_LAG;
    localparam logic [15:0] BIT_AT   = 16'(CLK_DIV - 1) + SAMPLE_LAG;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_s_q;
    logic        rx_bit;
    logic        fall;
    logic        sample_tick;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [1:0]  mode;
    logic        par_acc;
    logic        par_err;

    // NOTE: synchroniser resets to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            rx_meta <= RX_pin;
            rx_s    <= rx_meta;
            rx_s_q  <= rx_s;
        end
    end

    assign fall = rx_s_q & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rx_hist <= 2'b11;
        else     rx_hist <= {rx_hist[0], rx_s};
    end

    // Decision one cycle late: votes on the samples at S-1, S and S+1.
    assign rx_bit = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
    assign rx_bit = rx_s;
`endif

    assign sample_tick = (state == START) ? (cnt == START_AT) : (cnt == BIT_AT);

    // NOTE: every register here uses <= so all branches see the pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            mode    <= '0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
            RBUF    <= '0;
            Doneflg <= 1'b0;
            Parerr  <= 1'b0;
            Frmerr  <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            Doneflg <= 1'b0;
            cnt     <= cnt + 16'd1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state   <= START;
                        mode    <= FrameCheck;
                        bit_idx <= '0;
                        par_acc <= 1'b0;
                        par_err <= 1'b0;
                        Busy    <= 1'b1;
                    end
                end
                START: if (sample_tick) begin
                    cnt <= SAMPLE_LAG;
                    if (rx_bit) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (sample_tick) begin
                    cnt            <= SAMPLE_LAG;
                    shreg[bit_idx] <= rx_bit;
                    par_acc        <= par_acc ^ rx_bit;
                    bit_idx        <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state <= (mode == 2'd1 || mode == 2'd2) ? PARITY : STOP;
                end
                PARITY: if (sample_tick) begin
                    cnt     <= SAMPLE_LAG;
                    par_err <= (mode == 2'd1) ? ~(par_acc ^ rx_bit) : (par_acc ^ rx_bit);
                    state   <= STOP;
                end
                STOP: if (sample_tick) begin
                    cnt     <= SAMPLE_LAG;
                    RBUF    <= shreg;
                    Parerr  <= par_err;
                    Frmerr  <= ~rx_bit;
                    Doneflg <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    cnt   <= '0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctl_module.sv
// Bench for uart_rx_ctl_module: frame-level reference model compared every cycle,
// plus literal expectations for bytes, flags and strobe latency.
module tb_uart_rx_ctl_module;
    localparam int D = 8;
    localparam int H = D / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT_NP = 79 + MAJ;
    localparam int LAT_P  = 87 + MAJ;
    localparam int HMAX   = 8192;

    logic       CLK;
    logic       RST;
    logic       RX_pin;
    logic [1:0] FrameCheck;
    logic [7:0] RBUF;
    logic       Doneflg;
    logic       Parerr;
    logic       Frmerr;
    logic       Busy;

    int errors = 0;
    int checks = 0;

    uart_rx_ctl_module #(.CLK_DIV(D)) dut (
        .CLK(CLK), .RST(RST), .RX_pin(RX_pin), .FrameCheck(FrameCheck),
        .RBUF(RBUF), .Doneflg(Doneflg), .Parerr(Parerr), .Frmerr(Frmerr), .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: line samples per clock edge, frame decoded by bit-period arithmetic.
    int         cyc = 0;
    bit         hist [0:HMAX-1];
    bit         in_frame = 1'b0;
    int         n0 = 0;
    int         nbits = 10;
    int         idle_from = 0;
    int         busy_off_at = -1;
    int         m_rel;
    int         m_k;
    bit         m_v;
    bit         m_xr;
    bit         m_bits [0:10];
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_byte;
    logic [7:0] m_rbuf = 8'h00;
    bit         m_done = 1'b0;
    bit         m_par = 1'b0;
    bit         m_frm = 1'b0;
    bit         m_busy = 1'b0;

    function automatic bit decide(input int x);
`ifdef UART_RX_MAJORITY_EN
        return (hist[x-1] & hist[x]) | (hist[x-1] & hist[x+1]) | (hist[x] & hist[x+1]);
`else
        return hist[x];
`endif
    endfunction

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (cyc < HMAX) hist[cyc] = RST ? 1'b1 : RX_pin;
        m_done = 1'b0;
        if (RST) begin
            in_frame = 1'b0; idle_from = 0; busy_off_at = -1;
            m_rbuf = 8'h00; m_par = 1'b0; m_frm = 1'b0; m_busy = 1'b0;
        end else begin
            if (cyc == busy_off_at) m_busy = 1'b0;
            if (!in_frame) begin
                if (cyc >= idle_from && cyc >= 3 && hist[cyc-3] && !hist[cyc-2]) begin
                    in_frame = 1'b1;
                    n0       = cyc - 2;
                    m_mode   = FrameCheck;
                    nbits    = (FrameCheck == 2'd1 || FrameCheck == 2'd2) ? 11 : 10;
                    m_busy   = 1'b1;
                end
            end else begin
                m_rel = cyc - (n0 + 2 + H + MAJ);
                if (m_rel >= 0 && m_rel % D == 0) begin
                    m_k = m_rel / D;
                    m_v = decide(n0 + H + m_k * D);
                    m_bits[m_k] = m_v;
                    if (m_k == 0 && m_v) begin
                        in_frame = 1'b0; m_busy = 1'b0; idle_from = cyc + 1;
                    end else if (m_k == nbits - 1) begin
                        for (int i = 0; i < 8; i++) m_byte[i] = m_bits[i+1];
                        m_xr = (^m_byte) ^ m_bits[9];
                        m_par = (nbits == 11) ? ((m_mode == 2'd1) ? !m_xr : m_xr) : 1'b0;
                        m_frm = !m_v;
                        m_rbuf = m_byte;
                        m_done = 1'b1;
                        in_frame = 1'b0;
                        busy_off_at = cyc + 1;
                        idle_from = cyc + 2;
                    end
                end
            end
        end
    end

    logic [7:0] got_q [$];
    int         done_q [$];

    always @(negedge CLK) begin
        check("RBUF",    32'(RBUF),    RST ? 32'h0 : 32'(m_rbuf));
        check("Doneflg", 32'(Doneflg), RST ? 32'h0 : 32'(m_done));
        check("Parerr",  32'(Parerr),  RST ? 32'h0 : 32'(m_par));
        check("Frmerr",  32'(Frmerr),  RST ? 32'h0 : 32'(m_frm));
        check("Busy",    32'(Busy),    RST ? 32'h0 : 32'(m_busy));
        if (Doneflg === 1'b1) begin
            got_q.push_back(RBUF);
            done_q.push_back(cyc);
        end
    end

    int  last_start;
    int  n_before;
    bit  busy_seen;

    task automatic idle(input int n);
        RX_pin = 1'b1;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        for (int j = 0; j < D; j++) begin
            RX_pin = (glitch && j == H) ? ~v : v;
            @(posedge CLK); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic [1:0] fc, input logic [1:0] fc_after,
                              input bit has_par, input logic pbit, input logic stop, input bit glitch);
        FrameCheck = fc;
        last_start = cyc + 1;
        drive_bit(1'b0, glitch);
        FrameCheck = fc_after;
        for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
        if (has_par) drive_bit(pbit, glitch);
        drive_bit(stop, glitch);
        RX_pin = 1'b1;
    endtask

    task automatic expect_frames(input string name, input int n, input logic [7:0] last_byte);
        check({name, "_count"}, 32'(got_q.size()), 32'(n));
        if (got_q.size() > 0) check({name, "_byte"}, 32'(got_q[got_q.size()-1]), 32'(last_byte));
    endtask

    task automatic expect_latency(input string name, input int lat);
        if (done_q.size() > 0) check(name, 32'(done_q[done_q.size()-1] - last_start + 1), 32'(lat));
        else check(name, 32'hFFFF_FFFF, 32'(lat));
    endtask

    initial begin
        RST = 1'b1; RX_pin = 1'b1; FrameCheck = 2'd0;
        repeat (3) begin @(posedge CLK); #1; end
        check("rst_rbuf", 32'(RBUF), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_done", 32'(Doneflg), 32'h0);
        RST = 1'b0;
        idle(10);

        // 8N1 frame
        send_frame(8'hA5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        expect_frames("a5", 1, 8'hA5);
        expect_latency("a5_latency", LAT_NP);
        check("a5_parerr", 32'(Parerr), 32'h0);
        check("a5_frmerr", 32'(Frmerr), 32'h0);

        // parity modes; the last one changes FrameCheck mid-frame
        send_frame(8'h03, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        expect_frames("odd_ok", 2, 8'h03);
        expect_latency("odd_latency", LAT_P);
        check("odd_ok_parerr", 32'(Parerr), 32'h0);
        send_frame(8'h03, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("odd_bad_parerr", 32'(Parerr), 32'h1);
        send_frame(8'h03, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("even_ok_parerr", 32'(Parerr), 32'h0);
        send_frame(8'h03, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        expect_frames("fc_hold", 5, 8'h03);
        check("fc_hold_parerr", 32'(Parerr), 32'h1);
        send_frame(8'hA5, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        expect_frames("mode3", 6, 8'hA5);
        check("mode3_parerr", 32'(Parerr), 32'h0);

        // framing error followed by a stuck-low line
        FrameCheck = 2'd0;
        send_frame(8'h5A, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        RX_pin = 1'b0;
        repeat (3 * D) begin @(posedge CLK); #1; end
        expect_frames("brk", 7, 8'h5A);
        check("brk_frmerr", 32'(Frmerr), 32'h1);
        idle(2 * D);
        check("brk_quiet", 32'(got_q.size()), 32'd7);
        send_frame(8'h81, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        expect_frames("after_brk", 8, 8'h81);
        check("after_brk_frmerr", 32'(Frmerr), 32'h0);

        // false start: 2-cycle low pulse
        busy_seen = 1'b0;
        RX_pin = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        RX_pin = 1'b1;
        repeat (2 * D) begin @(posedge CLK); #1; busy_seen |= Busy; end
        check("false_busy_seen", 32'(busy_seen), 32'h1);
        check("false_busy_end", 32'(Busy), 32'h0);
        expect_frames("false", 8, 8'h81);
        check("false_rbuf", 32'(RBUF), 32'h81);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("b2b_count", 32'(got_q.size()), 32'd10);
        if (got_q.size() >= 2) check("b2b_first", 32'(got_q[got_q.size()-2]), 32'h00);
        expect_frames("b2b_second", 10, 8'hFF);

        // reset during data bit 4 of 8'hC3
        n_before = got_q.size();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i), 1'b0);
        RX_pin = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b1; RX_pin = 1'b1;
        #1;
        check("abort_rbuf", 32'(RBUF), 32'h0);
        check("abort_busy", 32'(Busy), 32'h0);
        check("abort_done", 32'(Doneflg), 32'h0);
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b0;
        idle(2 * D);
        check("abort_nostrobe", 32'(got_q.size()), 32'(n_before));
        send_frame(8'h3C, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, MAJ == 1);
        idle(2 * D);
        expect_frames("recover", n_before + 1, 8'h3C);
        check("recover_rbuf", 32'(RBUF), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctl_module.md
Name: uart_rx_ctl_module

Overview:
UART receive controller, the receive-side counterpart of the UART transmit controller. Oversamples RX_pin with an internal bit-period counter and recovers start, 8 data bits (LSB first), an optional parity bit and the stop bit. Presents the byte in RBUF with a one-cycle Doneflg strobe plus parity and framing error flags. FrameCheck encoding matches the transmitter: 0 = none, 1 = odd, 2 = even, 3 = treated as none.

Parameters:
CLK_DIV, 434, CLK cycles per bit (50 MHz / 115200); legal range 4..65535
HALF_DIV, CLK_DIV/2, cycles from start-edge detection to the start-bit sample point (derived, not overridden)

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
RX_pin  input  1  serial line, idle high, asynchronous to CLK
FrameCheck  input  2  parity mode; sampled at start-edge detection, held for the frame
RBUF  output  8  received byte
Doneflg  output  1  one-cycle strobe: frame complete, RBUF/flags valid
Parerr  output  1  parity mismatch on the last frame
Frmerr  output  1  stop bit sampled low on the last frame
Busy  output  1  high while not IDLE

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: RBUF=8'h00, Doneflg=0, Parerr=0, Frmerr=0, Busy=0. Synchroniser flops reset to 1. State=IDLE, bit counter cleared.
- RX_pin passes through a 2-flop synchroniser (rx_s). A falling edge means the previous rx_s is 1 and the current rx_s is 0.
- A 16-bit cycle counter cnt is cleared on every state entry and on every sample.
- IDLE: on a falling edge, go to START, latch FrameCheck, cnt=0, Busy=1.
- START: sample at cnt==HALF_DIV-1.
  - rx_s==1: false start; return to IDLE with no strobe and no flag change.
  - rx_s==0: go to DATA, bit index=0.
- DATA: sample at cnt==CLK_DIV-1. Shift the bit into a shift register at position [index], LSB first, and accumulate XOR parity. After index 7, go to PARITY if the latched mode is 1 or 2, otherwise go to STOP.
- PARITY: sample at cnt==CLK_DIV-1.
  - Odd mode: error if XOR(data,parity)==0.
  - Even mode: error if XOR(data,parity)==1.
  - Go to STOP.
- STOP: sample at cnt==CLK_DIV-1, then go to DONE.
- DONE: lasts one cycle.
  - RBUF<=shift register; Doneflg=1; Parerr<=computed value (0 in none mode); Frmerr<=~stop sample.
  - Return to IDLE; Busy drops the next cycle.
- Doneflg is a single-cycle pulse. RBUF, Parerr and Frmerr hold until the next DONE.
- A framing error still delivers the byte and the strobe.
- Return to IDLE happens at mid-stop-bit, so back-to-back frames (next start edge half a bit later) are received without loss.
- Break or stuck-low line: after a frame with Frmerr, no new frame starts until rx_s has returned high and then falls again. There is no repeated triggering on a constant low.
- Latency: Doneflg asserts 2 (sync) + HALF_DIV + (8+p+1)·CLK_DIV + 1 cycles after the RX_pin falling edge, where p=1 with parity and 0 without.
- FrameCheck changes mid-frame have no effect.
- RST mid-frame aborts immediately to the reset values. The partial byte is discarded and no strobe is produced.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every sample point (start, data, parity, stop) uses a 2-of-3 majority of rx_s at cnt==S-1, S and S+1, where S is the nominal sample index. The decision is taken at S+1; the counter reset keeps the bit period unchanged, so total latency grows by 1 cycle. A single-cycle glitch at the sample point is rejected.
- Undefined: a single sample at the nominal point, as described above.

Test Plan:
- CLK_DIV=8, FrameCheck=0, send 8'hA5 with stop=1 -> one Doneflg pulse, RBUF=8'hA5, Parerr=0, Frmerr=0, pulse at the computed latency.
- CLK_DIV=8, FrameCheck=1, send 8'h03 with parity bit 1 -> RBUF=8'h03, Parerr=0. Repeat with parity bit 0 -> Parerr=1. With FrameCheck=2 and 8'h03, parity 0 -> Parerr=0.
- Send 8'h5A with stop=0, then hold the line low for 3 bit times -> one strobe, Frmerr=1, no further Doneflg until the line goes high and falls again.
- Low pulse of 2 cycles on an idle line -> false start, return to IDLE, Busy high then low, no Doneflg, RBUF unchanged.
- Two frames back-to-back (8'h00 then 8'hFF), no idle gap -> two strobes, RBUF 8'h00 then 8'hFF.
- Assert RST during DATA bit 4 of frame 8'hC3 -> all outputs reset at once, no Doneflg. The next full frame 8'h3C is received correctly. With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at each sample point still yields 8'h3C.
